// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
// Round-robin arbiter/sequencer that shares one Wishbone master between
// NUM_REQ local requesters. The winning requester's fields are registered
// onto the master inputs, a single start pulse is issued, and the arbiter
// then watches the bus ack/err/rty taps and returns a per-requester
// completion pulse, error flag and shared read data. All outputs are
// registered.
//
// Ports
//   wb_clk, wb_rst        clock, synchronous active-high reset
//   req_i                 per-requester request level
//   req_adr_i/sel/we/dat  flattened per-requester transaction fields
//   gnt_o                 one-hot grant, held from selection until DONE exits
//   done_o, err_o         one-cycle completion pulse and its error qualifier
//   rd_dat_o              read data of the last successful read
//   busy_o                arbiter not in IDLE
//   m_*_o                 drive the shared master's start/address/sel/we/data
//   bus_ack/err/rty/dat_i taps of the Wishbone bus
//
// state | meaning
// IDLE  | no transaction; search for next requester after 'last'
// ISSUE | fields registered onto master, start pulse high this cycle
// WAIT  | waiting for ack/err/rty from the bus (no timeout)
// DONE  | done_o/err_o high; fields, grant and busy cleared on exit
module wb_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int dw      = 32,
    parameter int aw      = 32
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*aw-1:0]  req_adr_i,
    input  logic [NUM_REQ*4-1:0]   req_sel_i,
    input  logic [NUM_REQ-1:0]     req_we_i,
    input  logic [NUM_REQ*dw-1:0]  req_dat_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic [dw-1:0]          rd_dat_o,
    output logic                   busy_o,
    output logic                   m_start_o,
    output logic [aw-1:0]          m_address_o,
    output logic [3:0]             m_selection_o,
    output logic                   m_write_o,
    output logic [dw-1:0]          m_data_wr_o,
    input  logic                   bus_ack_i,
    input  logic                   bus_err_i,
    input  logic                   bus_rty_i,
    input  logic [dw-1:0]          bus_dat_i
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [dw-1:0]        rd_dat_q, rd_dat_d;
    logic                 busy_q, busy_d;
    logic                 m_start_q, m_start_d;
    logic [aw-1:0]        m_adr_q, m_adr_d;
    logic [3:0]           m_sel_q, m_sel_d;
    logic                 m_we_q, m_we_d;
    logic [dw-1:0]        m_dat_q, m_dat_d;

    logic [IW-1:0]        winner;
    logic                 found;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Circular search starting just after the previous winner. The candidate
    // index carries one extra bit so last+k can be folded back into range
    // for non-power-of-two NUM_REQ.
    always_comb begin
        logic [IW:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = '0;
        rd_dat_d  = rd_dat_q;
        busy_d    = busy_q;
        m_start_d = 1'b0;
        m_adr_d   = m_adr_q;
        m_sel_d   = m_sel_q;
        m_we_d    = m_we_q;
        m_dat_d   = m_dat_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d     = winner;
                    last_d    = winner;
                    gnt_d     = onehot(winner);
                    busy_d    = 1'b1;
                    m_start_d = 1'b1;
                    m_adr_d   = req_adr_i[winner*aw +: aw];
                    m_sel_d   = req_sel_i[winner*4 +: 4];
                    m_we_d    = req_we_i[winner];
                    m_dat_d   = req_dat_i[winner*dw +: dw];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Bus taps are deliberately ignored here: any response seen
                // in the start cycle belongs to nothing we issued.
                state_d = WAIT;
            end
            WAIT: begin
                if (bus_err_i || bus_rty_i) begin
                    done_d  = onehot(idx_q);
                    err_d   = onehot(idx_q);
                    state_d = DONE;
                end else if (bus_ack_i) begin
                    done_d = onehot(idx_q);
                    if (!m_we_q) begin
                        rd_dat_d = bus_dat_i;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // One dead IDLE cycle follows, giving the master time to
                // return to its own idle state before the next start.
                gnt_d   = '0;
                busy_d  = 1'b0;
                m_adr_d = '0;
                m_sel_d = '0;
                m_we_d  = 1'b0;
                m_dat_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= IW'(NUM_REQ-1);
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rd_dat_q  <= '0;
            busy_q    <= 1'b0;
            m_start_q <= 1'b0;
            m_adr_q   <= '0;
            m_sel_q   <= '0;
            m_we_q    <= 1'b0;
            m_dat_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_dat_q  <= rd_dat_d;
            busy_q    <= busy_d;
            m_start_q <= m_start_d;
            m_adr_q   <= m_adr_d;
            m_sel_q   <= m_sel_d;
            m_we_q    <= m_we_d;
            m_dat_q   <= m_dat_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign rd_dat_o      = rd_dat_q;
    assign busy_o        = busy_q;
    assign m_start_o     = m_start_q;
    assign m_address_o   = m_adr_q;
    assign m_selection_o = m_sel_q;
    assign m_write_o     = m_we_q;
    assign m_data_wr_o   = m_dat_q;

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
Round-robin arbiter and sequencer that shares one wb_master_interface instance between NUM_REQ local requesters (DSP engines, DMA, debug port).
- Selects one requester and drives that master's start/address/selection/write/data_wr inputs, registered.
- Taps the Wishbone bus for ack/err/rty and read data.
- Returns a per-requester completion pulse, error flag and read data.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
dw, 32, data width
aw, 32, address width

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  synchronous active-high reset
req_i  in  NUM_REQ  per-requester transaction request (level)
req_adr_i  in  NUM_REQ*aw  flattened addresses, requester n at [n*aw +: aw]
req_sel_i  in  NUM_REQ*4  flattened byte selects
req_we_i  in  NUM_REQ  1 = write
req_dat_i  in  NUM_REQ*dw  flattened write data
gnt_o  out  NUM_REQ  one-hot grant
done_o  out  NUM_REQ  one-cycle completion pulse, one-hot
err_o  out  NUM_REQ  qualifies done_o: transaction ended in err/rty
rd_dat_o  out  dw  read data of last completed read
busy_o  out  1  arbiter not in IDLE
m_start_o  out  1  to master start
m_address_o  out  aw  to master address
m_selection_o  out  4  to master selection
m_write_o  out  1  to master write
m_data_wr_o  out  dw  to master data_wr
bus_ack_i  in  1  Wishbone ack tap
bus_err_i  in  1  Wishbone err tap
bus_rty_i  in  1  Wishbone rty tap
bus_dat_i  in  dw  Wishbone read data tap

Behaviour:
- All outputs are registered.
- Reset: state IDLE. gnt_o, done_o, err_o, rd_dat_o, busy_o, m_* all 0. Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority after reset.
- Reset mid-transaction aborts tracking immediately. No done_o is issued. The master is reset by the same wb_rst.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_i is set, pick the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Latch idx = winner and last = winner.
  - Register req_adr/sel/we/dat[idx] onto m_*.
  - Set gnt_o[idx] and busy_o. Go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: m_start_o = 1 for exactly this cycle; m_* fields held. Go to WAIT.
- WAIT:
  - m_start_o = 0; fields held.
  - bus_ack_i/err/rty are sampled only in WAIT, never in ISSUE.
  - bus_err_i | bus_rty_i takes priority over ack: set err_o[idx] = 1 and done_o[idx] = 1 for the next cycle, leave rd_dat_o unchanged, go to DONE.
  - else bus_ack_i: done_o[idx] = 1 next cycle; if m_write_o = 0, capture bus_dat_i into rd_dat_o. Go to DONE.
  - else stay in WAIT, with no timeout.
- DONE:
  - done_o/err_o are high this single cycle.
  - Clear gnt_o, m_* fields and busy_o on exit. Return to IDLE.
  - This gives the master's ERROR→IDLE turnaround before the next start.
- Minimum spacing: start to next start is 4 cycles plus slave wait states.
- Requester contract: hold req_i and fields stable until done_o. After done_o, it drops req_i or keeps it to request again.
- Dropping req_i while granted is ignored; the transaction completes and done_o still pulses.
- Requests arriving in ISSUE/WAIT/DONE wait for IDLE. Grants never preempt.
- rd_dat_o is shared and valid in the done_o cycle; it holds until the next successful read.
- gnt_o and done_o are never multi-hot.

Test Plan:
1. Reset, then req_i = 0001, addr 0x100, we = 0, slave acks with 0xDEADBEEF → m_start_o high one cycle 1 cycle after req; done_o = 0001 and err_o = 0 one cycle after ack; rd_dat_o = 0xDEADBEEF.
2. req_i = 1111 held continuously → grant order 0,1,2,3,0; each done_o precedes the next m_start_o by 2 cycles; never two grants at once.
3. Write from req 2 (addr 0x20, data 0x12345678, sel 0xF) → m_* match exactly while gnt_o = 0100; rd_dat_o unchanged after ack.
4. Slave asserts err (then rty in a separate run) on req 1 → done_o = 0010 and err_o = 0010 same cycle; rd_dat_o unchanged; next start no earlier than 2 cycles later.
5. wb_rst asserted in WAIT for req 3 → next cycle all outputs 0, no done_o; first grant after reset goes to requester 0.
6. req 0 drops req_i mid-WAIT with req 1 pending; slave ack after 5 wait states → done_o = 0001 still pulses, then requester 1 is granted.
